// File: rtl/hls_fp32_chn_in_rsci_if.sv
// Upstream operand channel (valid/ready/data) feeding the fp32 input-channel block.
//   vld  : producer has an operand on data
//   rdy  : consumer can accept an operand this cycle
//   data : operand payload, WIDTH bits
// master = upstream producer, slave = hls_fp32_chn_in_rsci.
interface hls_fp32_chn_in_rsci_if #(
    parameter int unsigned WIDTH = 32
);
    logic             vld;
    logic             rdy;
    logic [WIDTH-1:0] data;

    modport master (output vld, output data, input rdy);
    modport slave  (input vld, input data, output rdy);
endinterface

// File: rtl/hls_fp32_chn_in_rsci.sv
// Input-channel interface for the fp32 HLS cores.
// Buffers upstream operands in a 2-entry skid FIFO, reports operand availability
// to the core staller (chn_in_rsci_wen_comp), presents the head operand to the
// datapath and pops it only when the whole core advances (core_wen).
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   chn_in                           : upstream vld/rdy/data channel (rdy registered)
//   rsci_oswt                        : core wants to read this channel this cycle
//   core_wen / core_wten             : global advance / stalled-last-cycle from the staller
//   chn_in_rsci_wen_comp             : this channel is not blocking the core (comb.)
//   chn_in_rsci_d_mxwt               : head operand to the datapath (comb. from state)
//   stall_blame_cnt / stall_blame_clr: saturating count of stalls caused here, sync clear
module hls_fp32_chn_in_rsci #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    hls_fp32_chn_in_rsci_if.slave    chn_in,
    input  logic                     rsci_oswt,
    input  logic                     core_wen,
    input  logic                     core_wten,
    output logic                     chn_in_rsci_wen_comp,
    output logic [WIDTH-1:0]         chn_in_rsci_d_mxwt,
    output logic [CNT_W-1:0]         stall_blame_cnt,
    input  logic                     stall_blame_clr
);

    localparam int unsigned DEPTH = 2;
    localparam logic [1:0]  FULL  = 2'd2;
    localparam logic [CNT_W-1:0] BLAME_MAX = '1;

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [1:0]       count_q;
    logic [1:0]       count_nxt;
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic             rdy_q;
    logic             hold_q;
    logic             push;
    logic             pop;
    logic             blame_inc;

    // Handshake decode and occupancy update
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        blame_inc = 1'b0;
        count_nxt = count_q;
        push      = chn_in.vld & rdy_q;
        pop       = rsci_oswt & core_wen & (count_q != 2'd0);
        blame_inc = rsci_oswt & ~core_wen & (count_q == 2'd0);
        case ({push, pop})
            2'b10:   count_nxt = count_q + 2'd1;
            2'b01:   count_nxt = count_q - 2'd1;
            default: count_nxt = count_q;
        endcase
    end

    // FIFO storage, pointers and registered upstream ready
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            rdy_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            if (push) begin
                entry_q[wr_ptr_q] <= chn_in.data;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_nxt;
            rdy_q   <= (count_nxt < FULL);
            // Head was shown to a stalled core; it must still be there next cycle
            hold_q  <= rsci_oswt & (count_q != 2'd0) & ~pop;
        end
    end

    // Saturating stall-blame counter; clear wins over increment
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_blame_cnt <= '0;
        end else if (stall_blame_clr) begin
            stall_blame_cnt <= '0;
        end else if (blame_inc && (stall_blame_cnt != BLAME_MAX)) begin
            stall_blame_cnt <= stall_blame_cnt + CNT_W'(1);
        end
    end

    assign chn_in.rdy           = rdy_q;
    assign chn_in_rsci_wen_comp = ~rsci_oswt | (count_q != 2'd0);

    // When empty, rd_ptr has already moved past the last popped slot, which a
    // following push cannot overwrite (it lands at wr_ptr == rd_ptr); showing
    // that slot keeps the last popped operand on the datapath.
    assign chn_in_rsci_d_mxwt = (count_q != 2'd0) ? entry_q[rd_ptr_q] : entry_q[~rd_ptr_q];

    a_head_stable: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        (hold_q && core_wten && rsci_oswt) |-> (chn_in_rsci_d_mxwt == $past(chn_in_rsci_d_mxwt)));

    a_count_range: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
        count_q <= FULL);

endmodule

// File: tb/tb_hls_fp32_chn_in_rsci.sv
module tb_hls_fp32_chn_in_rsci;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned BLAME_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rstn;
    logic             rsci_oswt;
    logic             core_wen;
    logic             core_wten;
    logic             wen_comp;
    logic [WIDTH-1:0] d_mxwt;
    logic [CNT_W-1:0] blame_cnt;
    logic             blame_clr;

    hls_fp32_chn_in_rsci_if #(.WIDTH(WIDTH)) chn_in_if ();

    hls_fp32_chn_in_rsci #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk       (clk),
        .nvdla_core_rstn      (rstn),
        .chn_in               (chn_in_if),
        .rsci_oswt            (rsci_oswt),
        .core_wen             (core_wen),
        .core_wten            (core_wten),
        .chn_in_rsci_wen_comp (wen_comp),
        .chn_in_rsci_d_mxwt   (d_mxwt),
        .stall_blame_cnt      (blame_cnt),
        .stall_blame_clr      (blame_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Staller-side registered ~core_wen
    always @(posedge clk or negedge rstn) begin
        if (!rstn) core_wten <= 1'b0;
        else       core_wten <= ~core_wen;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a plain queue, occupancy = queue size
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_popped;
    logic             model_rdy;
    int unsigned      model_blame;

    // Monitor/scoreboard: at each falling edge compare DUT against the model,
    // then advance the model by the handshakes the coming rising edge will see.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q.delete();
            last_popped = '0;
            model_rdy   = 1'b0;
            model_blame = 0;
        end else begin
            int sz;
            sz = exp_q.size();
            check("rdy", 32'(chn_in_if.rdy), 32'(model_rdy));
            check("wen_comp", 32'(wen_comp), 32'(!rsci_oswt || sz != 0));
            check("blame_cnt", 32'(blame_cnt), 32'(model_blame));
            if (sz != 0) check("d_mxwt_head", d_mxwt, exp_q[0]);
            else         check("d_mxwt_hold", d_mxwt, last_popped);

            if (blame_clr) model_blame = 0;
            else if (rsci_oswt && !core_wen && sz == 0 && model_blame < BLAME_MAX)
                model_blame = model_blame + 1;

            if (rsci_oswt && core_wen && sz != 0) last_popped = exp_q.pop_front();
            if (chn_in_if.vld && model_rdy) exp_q.push_back(chn_in_if.data);
            model_rdy = (exp_q.size() < 2);
        end
    end

    // Upstream source: holds vld/data until accepted
    logic [WIDTH-1:0] src_q[$];
    logic             vld_en;

    task automatic step();
        bit acc;
        chn_in_if.vld  = vld_en && (src_q.size() != 0);
        chn_in_if.data = (src_q.size() != 0) ? src_q[0] : '0;
        @(negedge clk);
        acc = chn_in_if.vld && chn_in_if.rdy;
        @(posedge clk);
        #1;
        if (acc) void'(src_q.pop_front());
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rstn = 1'b0;
        rsci_oswt = 1'b0;
        core_wen = 1'b0;
        blame_clr = 1'b0;
        vld_en = 1'b0;
        chn_in_if.vld = 1'b0;
        chn_in_if.data = '0;

        // Reset state
        steps(2);
        rsci_oswt = 1'b1;
        #1;
        check("rst_rdy", 32'(chn_in_if.rdy), 32'd0);
        check("rst_wen_comp", 32'(wen_comp), 32'd0);
        check("rst_blame", 32'(blame_cnt), 32'd0);
        check("rst_d_mxwt", d_mxwt, 32'd0);
        rsci_oswt = 1'b0;
        rstn = 1'b1;
        step();
        check("rdy_after_release", 32'(chn_in_if.rdy), 32'd1);

        // Single operand: pushed in N, at head in N+1, popped, empty at N+2
        src_q.push_back(32'h3F80_0000);
        vld_en = 1'b1;
        step();
        rsci_oswt = 1'b1;
        core_wen = 1'b1;
        #1;
        check("single_wen_comp", 32'(wen_comp), 32'd1);
        check("single_head", d_mxwt, 32'h3F80_0000);
        step();
        check("single_empty", 32'(wen_comp), 32'd0);
        check("single_hold", d_mxwt, 32'h3F80_0000);

        // Streaming 1..10 at full throughput
        for (int i = 1; i <= 10; i++) src_q.push_back(WIDTH'(i));
        steps(12);
        check("stream_done", 32'(exp_q.size()), 32'd0);

        // Backpressure: core stalled, third operand held upstream
        for (int i = 0; i < 3; i++) src_q.push_back(32'h100 + 32'(i));
        core_wen = 1'b0;
        steps(4);
        check("bp_rdy_low", 32'(chn_in_if.rdy), 32'd0);
        check("bp_src_held", 32'(src_q.size()), 32'd1);
        core_wen = 1'b1;
        steps(6);
        check("bp_src_drained", 32'(src_q.size()), 32'd0);

        // Stall caused by another channel while an operand is presented
        blame_clr = 1'b1;
        step();
        blame_clr = 1'b0;
        rsci_oswt = 1'b0;
        core_wen = 1'b0;
        src_q.push_back(32'h0000_0ABC);
        step();
        rsci_oswt = 1'b1;
        steps(4);
        check("stall_head", d_mxwt, 32'h0000_0ABC);
        check("stall_blame", 32'(blame_cnt), 32'd0);
        core_wen = 1'b1;
        steps(2);

        // Blame saturation and clear
        core_wen = 1'b0;
        steps(5);
        check("blame_sat", 32'(blame_cnt), 32'(BLAME_MAX));
        blame_clr = 1'b1;
        step();
        check("blame_clr", 32'(blame_cnt), 32'd0);
        blame_clr = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            if (src_q.size() < 2) src_q.push_back($urandom);
            vld_en    = ($urandom_range(0, 3) != 0);
            rsci_oswt = ($urandom_range(0, 4) != 0);
            core_wen  = ($urandom_range(0, 2) != 0);
            blame_clr = ($urandom_range(0, 30) == 0);
            step();
        end

        // Drain, fill to two, then reset asynchronously mid-operation
        blame_clr = 1'b0;
        vld_en = 1'b0;
        rsci_oswt = 1'b1;
        core_wen = 1'b1;
        steps(3);
        src_q.delete();
        for (int i = 0; i < 3; i++) src_q.push_back(32'h200 + 32'(i));
        vld_en = 1'b1;
        rsci_oswt = 1'b0;
        core_wen = 1'b0;
        steps(3);
        check("pre_rst_full", 32'(chn_in_if.rdy), 32'd0);
        #2;
        rstn = 1'b0;
        rsci_oswt = 1'b1;
        #1;
        check("async_rst_rdy", 32'(chn_in_if.rdy), 32'd0);
        check("async_rst_wen_comp", 32'(wen_comp), 32'd0);
        check("async_rst_d_mxwt", d_mxwt, 32'd0);
        src_q.delete();
        vld_en = 1'b0;
        rsci_oswt = 1'b0;
        chn_in_if.vld = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        steps(3);
        check("post_rst_rdy", 32'(chn_in_if.rdy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
